timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_if.sv | 28 ++
 rtl/timer_ctrl.sv | 131 +++++++++++++
 tb/tb_timer_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// Button, datapath-status and control signals between the countdown
// controller (slave) and the surrounding datapath/UI logic (master).
interface timer_ctrl_if;
    logic        btn_start;
    logic        btn_reset;
    logic        btn_mode;
    logic        btn_min;
    logic        btn_hour;
    logic        time_zero;
    logic        tick;
    logic        en;
    logic        rst_state;
    logic        setting;
    logic [5:0]  min_ini;
    logic [5:0]  hour_ini;
    logic [15:0] LED_control;
    logic [1:0]  state;

    modport master (
        output btn_start, btn_reset, btn_mode, btn_min, btn_hour, time_zero, tick,
        input  en, rst_state, setting, min_ini, hour_ini, LED_control, state
    );

    modport slave (
        input  btn_start, btn_reset, btn_mode, btn_min, btn_hour, time_zero, tick,
        output en, rst_state, setting, min_ini, hour_ini, LED_control, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// Countdown timer sequencing FSM with preset registers and DONE alarm pattern.
// Define TIMER_CTRL_BLINK_EN to make the DONE alarm blink on tick instead of staying lit.
//
// state | meaning
// SET   | presets editable, datapath held loaded (rst_state=1)
// RUN   | countdown enabled
// PAUSE | countdown halted, resumable
// DONE  | countdown reached zero, alarm active
module timer_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    timer_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        SET   = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] min_q, min_d;
    logic [5:0] hour_q, hour_d;
    logic       reload_d;
    logic       phase_q, phase_d;
    logic       en_q, rst_state_q, setting_q;

    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        hour_d   = hour_q;
        reload_d = 1'b0;
        case (state_q)
            SET: begin
                if (bus.btn_reset || bus.btn_mode) begin
                    // higher-priority buttons do nothing here but still mask the others
                end else if (bus.btn_start) begin
                    if ((min_q != 6'd0) || (hour_q != 6'd0)) begin
                        state_d = RUN;
                    end
                end else begin
                    if (bus.btn_min) begin
                        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    end
                    if (bus.btn_hour) begin
                        hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                    end
                end
            end
            RUN: begin
                if (bus.btn_reset) begin
                    state_d  = PAUSE;
                    reload_d = 1'b1;
                end else if (bus.time_zero) begin
                    state_d = DONE;
                end else if (bus.btn_start && !bus.btn_mode) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (bus.btn_reset) begin
                    reload_d = 1'b1;
                end else if (bus.btn_mode) begin
                    state_d = SET;
                end else if (bus.btn_start && !bus.time_zero) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.btn_reset) begin
                    state_d  = PAUSE;
                    reload_d = 1'b1;
                end else if (bus.btn_mode) begin
                    state_d = SET;
                end else if (bus.btn_start) begin
                    state_d  = PAUSE;
                    reload_d = 1'b1;
                end
            end
            default: state_d = SET;
        endcase
    end

`ifdef TIMER_CTRL_BLINK_EN
    always_comb begin
        phase_d = 1'b0;
        if (state_d == DONE) begin
            if (state_q != DONE) begin
                phase_d = 1'b1;
            end else begin
                phase_d = bus.tick ? ~phase_q : phase_q;
            end
        end
    end
`else
    logic unused_tick;
    assign unused_tick = bus.tick;

    always_comb begin
        phase_d = (state_d == DONE);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SET;
            min_q       <= 6'd0;
            hour_q      <= 6'd0;
            phase_q     <= 1'b0;
            en_q        <= 1'b0;
            rst_state_q <= 1'b1;
            setting_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            phase_q     <= phase_d;
            en_q        <= (state_d == RUN);
            rst_state_q <= (state_d == SET) || reload_d;
            setting_q   <= (state_d == SET);
        end
    end

    assign bus.state       = state_q;
    assign bus.min_ini     = min_q;
    assign bus.hour_ini    = hour_q;
    assign bus.en          = en_q;
    assign bus.rst_state   = rst_state_q;
    assign bus.setting     = setting_q;
    assign bus.LED_control = {16{phase_q}};
endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios with literal expectations plus
// randomized button traffic checked every cycle against a behavioural model.
module tb_timer_ctrl;
    localparam logic [6:0] B_START = 7'h01;
    localparam logic [6:0] B_RESET = 7'h02;
    localparam logic [6:0] B_MODE  = 7'h04;
    localparam logic [6:0] B_MIN   = 7'h08;
    localparam logic [6:0] B_HOUR  = 7'h10;
    localparam logic [6:0] B_TZ    = 7'h20;
    localparam logic [6:0] B_TICK  = 7'h40;

    localparam int S_SET   = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

`ifdef TIMER_CTRL_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    timer_ctrl_if bus();

    timer_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int          m_state;
    int          m_min;
    int          m_hour;
    bit          m_pulse;
    int          m_led;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [6:0] b);
        @(posedge clk);
        #2;
        bus.btn_start = b[0];
        bus.btn_reset = b[1];
        bus.btn_mode  = b[2];
        bus.btn_min   = b[3];
        bus.btn_hour  = b[4];
        bus.time_zero = b[5];
        bus.tick      = b[6];
    endtask

    // Reference model: highest-priority pressed button decides; time_zero ends RUN unless reloading.
    always @(posedge clk) begin : model
        int nxt;
        if (!rst_n) begin
            m_state = S_SET;
            m_min   = 0;
            m_hour  = 0;
            m_pulse = 1'b0;
            m_led   = 0;
        end else begin
            nxt     = m_state;
            m_pulse = 1'b0;
            if (bus.btn_reset && m_state != S_SET) begin
                nxt     = S_PAUSE;
                m_pulse = 1'b1;
            end else if (m_state == S_RUN && bus.time_zero) begin
                nxt = S_DONE;
            end else if (bus.btn_reset) begin
                nxt = m_state;
            end else if (bus.btn_mode) begin
                if (m_state == S_PAUSE || m_state == S_DONE) nxt = S_SET;
            end else if (bus.btn_start) begin
                if (m_state == S_SET && (m_min + m_hour) > 0) nxt = S_RUN;
                else if (m_state == S_RUN) nxt = S_PAUSE;
                else if (m_state == S_PAUSE && !bus.time_zero) nxt = S_RUN;
                else if (m_state == S_DONE) begin
                    nxt     = S_PAUSE;
                    m_pulse = 1'b1;
                end
            end else if (m_state == S_SET) begin
                m_min  = (m_min + (bus.btn_min ? 1 : 0)) % 60;
                m_hour = (m_hour + (bus.btn_hour ? 1 : 0)) % 24;
            end
            if (nxt != S_DONE) m_led = 0;
            else if (m_state != S_DONE) m_led = 'hFFFF;
            else if (BLINK && bus.tick) m_led = m_led ^ 'hFFFF;
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", int'(bus.state), m_state);
            check("min_ini", int'(bus.min_ini), m_min);
            check("hour_ini", int'(bus.hour_ini), m_hour);
            check("en", int'(bus.en), (m_state == S_RUN) ? 1 : 0);
            check("rst_state", int'(bus.rst_state), (m_state == S_SET || m_pulse) ? 1 : 0);
            check("setting", int'(bus.setting), (m_state == S_SET) ? 1 : 0);
            check("LED_control", int'(bus.LED_control), m_led);
        end
    end

    initial begin
        bus.btn_start = 1'b0;
        bus.btn_reset = 1'b0;
        bus.btn_mode  = 1'b0;
        bus.btn_min   = 1'b0;
        bus.btn_hour  = 1'b0;
        bus.time_zero = 1'b0;
        bus.tick      = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        cyc(7'h00);
        check("lit_rst_state", int'(bus.state), 0);
        check("lit_rst_min", int'(bus.min_ini), 0);
        check("lit_rst_hour", int'(bus.hour_ini), 0);
        check("lit_rst_en", int'(bus.en), 0);
        check("lit_rst_rst_state", int'(bus.rst_state), 1);
        check("lit_rst_setting", int'(bus.setting), 1);
        check("lit_rst_led", int'(bus.LED_control), 0);
        rst_n = 1'b1;

        cyc(B_START); cyc(7'h00);
        check("lit_zero_start_state", int'(bus.state), 0);
        check("lit_zero_start_en", int'(bus.en), 0);

        repeat (5) cyc(B_MIN);
        cyc(B_HOUR); cyc(B_START); cyc(7'h00);
        check("lit_run_min", int'(bus.min_ini), 5);
        check("lit_run_hour", int'(bus.hour_ini), 1);
        check("lit_run_state", int'(bus.state), 1);
        check("lit_run_en", int'(bus.en), 1);
        check("lit_run_rst_state", int'(bus.rst_state), 0);

        cyc(B_RESET | B_MODE); cyc(7'h00);
        check("lit_reload_rst_state", int'(bus.rst_state), 1);
        check("lit_reload_state", int'(bus.state), 2);
        check("lit_reload_min", int'(bus.min_ini), 5);
        check("lit_reload_hour", int'(bus.hour_ini), 1);
        cyc(7'h00);
        check("lit_reload_pulse_end", int'(bus.rst_state), 0);

        cyc(B_START); cyc(7'h00);
        check("lit_resume_state", int'(bus.state), 1);
        cyc(B_START | B_TZ); cyc(7'h00);
        check("lit_done_state", int'(bus.state), 3);
        check("lit_done_en", int'(bus.en), 0);
        check("lit_done_led", int'(bus.LED_control), 'hFFFF);
        for (int k = 1; k <= 3; k++) begin
            cyc(B_TICK); cyc(7'h00);
            check("lit_blink_led", int'(bus.LED_control),
                  (BLINK && (k % 2 == 1)) ? 0 : 'hFFFF);
        end

        cyc(B_MODE); cyc(7'h00);
        check("lit_mode_state", int'(bus.state), 0);
        check("lit_mode_min", int'(bus.min_ini), 5);
        check("lit_mode_led", int'(bus.LED_control), 0);

        rst_n = 1'b0; cyc(7'h00); rst_n = 1'b1;
        repeat (59) cyc(B_MIN);
        cyc(7'h00);
        check("lit_min_59", int'(bus.min_ini), 59);
        cyc(B_MIN); cyc(7'h00);
        check("lit_min_wrap", int'(bus.min_ini), 0);
        repeat (23) cyc(B_HOUR);
        cyc(7'h00);
        check("lit_hour_23", int'(bus.hour_ini), 23);
        cyc(B_HOUR); cyc(7'h00);
        check("lit_hour_wrap", int'(bus.hour_ini), 0);
        cyc(B_MIN | B_HOUR); cyc(7'h00);
        check("lit_both_min", int'(bus.min_ini), 1);
        check("lit_both_hour", int'(bus.hour_ini), 1);

        cyc(B_START); cyc(7'h00);
        check("lit_run2_state", int'(bus.state), 1);
        rst_n = 1'b0; cyc(7'h00); rst_n = 1'b1;
        check("lit_midrun_rst_state", int'(bus.state), 0);
        check("lit_midrun_rst_en", int'(bus.en), 0);
        check("lit_midrun_rst_min", int'(bus.min_ini), 0);

        for (int i = 0; i < 4000; i++) begin
            logic [6:0] b;
            case ($urandom_range(0, 15))
                0:       b = B_START;
                1:       b = B_RESET;
                2:       b = B_MODE;
                3, 4:    b = B_MIN;
                5:       b = B_HOUR;
                6:       b = B_MIN | B_HOUR;
                7:       b = B_RESET | B_MODE;
                8:       b = B_RESET | B_START;
                default: b = 7'h00;
            endcase
            if ($urandom_range(0, 9) == 0) b = b | B_TZ;
            if ($urandom_range(0, 3) == 0) b = b | B_TICK;
            cyc(b);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1;
        cyc(7'h00);
        cyc(7'h00);
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
